// File: rtl/usart_pkg.sv
// Shared USART definitions: transmitter state encoding, parity modes and the
// data-width clamp used when a frame configuration is latched.
package usart_pkg;

    localparam int NBITS_W   = 5;
    localparam int NBITS_MIN = 5;

    localparam logic [1:0] PM_NONE = 2'b00;
    localparam logic [1:0] PM_EVEN = 2'b10;
    localparam logic [1:0] PM_ODD  = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP_1,
        TX_STOP_2,
        TX_BREAK,
        TX_BRK_STOP
    } tx_state_e;

    function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] n,
                                                       input int unsigned max_bits);
        if (32'(n) < NBITS_MIN) begin
            return NBITS_W'(NBITS_MIN);
        end
        if (32'(n) > max_bits) begin
            return NBITS_W'(max_bits);
        end
        return n;
    endfunction

endpackage

// File: rtl/usart_tx_engine_if.sv
// Register-file side of the USART transmitter: UDR write port, UCSR controls,
// baud enable and the status/serial outputs. slave = engine, master = driver.
interface usart_tx_engine_if #(
    parameter int DATA_MAX = 9,
    parameter int LVL_W    = 2
);
    logic                i_TXEN;
    logic                i_txclk;
    logic [4:0]          i_nbits;
    logic [1:0]          i_upm;
    logic                i_usbs;
    logic                i_brk;
    logic                i_wr_en;
    logic [DATA_MAX-1:0] i_wr_data;
    logic                o_txd;
    logic                o_udre;
    logic                o_txc;
    logic                o_busy;
    logic                o_ovr;
    logic [LVL_W-1:0]    o_level;

    modport slave (
        input  i_TXEN, i_txclk, i_nbits, i_upm, i_usbs, i_brk, i_wr_en, i_wr_data,
        output o_txd, o_udre, o_txc, o_busy, o_ovr, o_level
    );

    modport master (
        output i_TXEN, i_txclk, i_nbits, i_upm, i_usbs, i_brk, i_wr_en, i_wr_data,
        input  o_txd, o_udre, o_txc, o_busy, o_ovr, o_level
    );
endinterface

// File: rtl/usart_tx_fifo.sv
// Transmit holding FIFO: synchronous write, show-ahead read, level counter.
// Caller never writes when full without a same-cycle pop, nor pops when empty.
module usart_tx_fifo #(
    parameter int DATA_MAX   = 9,
    parameter int FIFO_DEPTH = 2,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                i_fosk,
    input  logic                i_rst_n,
    input  logic                i_wr_en,
    input  logic [DATA_MAX-1:0] i_wr_data,
    input  logic                i_rd_en,
    output logic [DATA_MAX-1:0] o_rd_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [LVL_W-1:0]    o_level
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_MAX-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = i_wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = i_rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q;
        case ({i_wr_en, i_rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_fosk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level counter alone decides what is valid.
    always_ff @(posedge i_fosk) begin
        if (i_wr_en) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[rd_ptr_q];
    assign o_empty   = (level_q == '0);
    assign o_full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign o_level   = level_q;

endmodule

// File: rtl/usart_tx_engine.sv
// USART transmitter: FIFO-fed frame sequencer with parity and break; o_txd is
// registered one cycle after the selecting txclk. Full FIFO drops writes and pulses o_ovr.
module usart_tx_engine
    import usart_pkg::*;
#(
    parameter int DATA_MAX   = 9,
    parameter int FIFO_DEPTH = 2,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             i_fosk,
    input  logic             i_rst_n,
    usart_tx_engine_if.slave tx_if
);
    tx_state_e           state_q, state_d;
    logic [DATA_MAX-1:0] sr_q, sr_d;
    logic [NBITS_W-1:0]  cnt_q, cnt_d;
    logic [NBITS_W-1:0]  nbits_q, nbits_d;
    logic [1:0]          upm_q, upm_d;
    logic                usbs_q, usbs_d;
    logic                par_q, par_d;
    logic                txd_q, txd_d;
    logic                txc_q, txc_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;

    logic                fifo_wr_en;
    logic                fifo_rd_en;
    logic [DATA_MAX-1:0] fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;

    logic                wr_attempt;
    logic                last_stop;
    logic                from_brk;
    logic                go_break;
    logic                load;

    usart_tx_fifo #(
        .DATA_MAX   (DATA_MAX),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) u_fifo (
        .i_fosk    (i_fosk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (fifo_wr_en),
        .i_wr_data (tx_if.i_wr_data),
        .i_rd_en   (fifo_rd_en),
        .o_rd_data (fifo_rd_data),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_level   (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        nbits_d    = nbits_q;
        upm_d      = upm_q;
        usbs_d     = usbs_q;
        par_d      = par_q;
        txd_d      = txd_q;
        txc_d      = 1'b0;
        last_stop  = 1'b0;
        from_brk   = 1'b0;
        go_break   = 1'b0;
        load       = 1'b0;
        fifo_rd_en = 1'b0;

        if (tx_if.i_txclk) begin
            case (state_q)
                TX_IDLE: begin
                    if (tx_if.i_brk && tx_if.i_TXEN) begin
                        go_break = 1'b1;
                    end else if (!fifo_empty && tx_if.i_TXEN && !tx_if.i_brk) begin
                        load = 1'b1;
                    end
                end
                TX_START: begin
                    state_d = TX_DATA;
                    txd_d   = sr_q[0];
                    sr_d    = sr_q >> 1;
                    par_d   = par_q ^ sr_q[0];
                    cnt_d   = '0;
                end
                TX_DATA: begin
                    if (cnt_q == nbits_q - 5'd1) begin
                        if (upm_q == PM_EVEN || upm_q == PM_ODD) begin
                            state_d = TX_PARITY;
                            txd_d   = par_q ^ (upm_q == PM_ODD);
                        end else begin
                            state_d = TX_STOP_1;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d = sr_q[0];
                        sr_d  = sr_q >> 1;
                        par_d = par_q ^ sr_q[0];
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                TX_PARITY: begin
                    state_d = TX_STOP_1;
                    txd_d   = 1'b1;
                end
                TX_STOP_1: begin
                    if (usbs_q) begin
                        state_d = TX_STOP_2;
                        txd_d   = 1'b1;
                    end else begin
                        last_stop = 1'b1;
                    end
                end
                TX_STOP_2: last_stop = 1'b1;
                TX_BREAK: begin
                    if (!tx_if.i_brk) begin
                        state_d = TX_BRK_STOP;
                        txd_d   = 1'b1;
                    end
                end
                TX_BRK_STOP: begin
                    last_stop = 1'b1;
                    from_brk  = 1'b1;
                end
                default: begin
                    state_d = TX_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end

        // Data already queued drains even after TXEN drops; only IDLE needs TXEN.
        if (last_stop) begin
            if (tx_if.i_brk) begin
                go_break = 1'b1;
            end else if (!fifo_empty) begin
                load = 1'b1;
            end else begin
                state_d = TX_IDLE;
                txd_d   = 1'b1;
                txc_d   = !from_brk;
            end
        end

        if (go_break) begin
            state_d = TX_BREAK;
            txd_d   = 1'b0;
        end

        if (load) begin
            fifo_rd_en = 1'b1;
            sr_d       = fifo_rd_data;
            nbits_d    = clamp_nbits(tx_if.i_nbits, DATA_MAX);
            upm_d      = tx_if.i_upm;
            usbs_d     = tx_if.i_usbs;
            par_d      = 1'b0;
            state_d    = TX_START;
            txd_d      = 1'b0;
        end

        busy_d = (state_d != TX_IDLE);
    end

    // A pop in the same cycle frees the slot, so the write is kept in that case.
    assign wr_attempt = tx_if.i_wr_en && tx_if.i_TXEN;
    assign fifo_wr_en = wr_attempt && (!fifo_full || fifo_rd_en);
    assign ovr_d      = wr_attempt && fifo_full && !fifo_rd_en;

    always_ff @(posedge i_fosk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= TX_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            nbits_q <= NBITS_W'(NBITS_MIN);
            upm_q   <= PM_NONE;
            usbs_q  <= 1'b0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            txc_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            nbits_q <= nbits_d;
            upm_q   <= upm_d;
            usbs_q  <= usbs_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign tx_if.o_txd   = txd_q;
    assign tx_if.o_txc   = txc_q;
    assign tx_if.o_busy  = busy_q;
    assign tx_if.o_ovr   = ovr_q;
    assign tx_if.o_udre  = !fifo_full;
    assign tx_if.o_level = fifo_level;

endmodule
